// File: rtl/led_arbiter.sv
// led_arbiter: fixed-priority LED bank sharing with minimum hold, per-requester blink and idle heartbeat
module led_arbiter #(
    parameter int NREQ        = 3,
    parameter int W           = 4,
    parameter int TICK_DIV    = 100000,
    parameter int BLINK_TICKS = 250,
    parameter int MIN_HOLD    = 500
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] pat_i,
    input  logic [NREQ-1:0]   blink_i,
    output logic [W-1:0]      led_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o
);
    localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
    localparam int HW = $clog2(MIN_HOLD + 1);
    typedef enum logic {IDLE, OWN} state_t;
    state_t         state, state_n;
    logic [GW-1:0]  g, g_n;
    logic [TW-1:0]  tick_cnt, tick_n;
    logic [BW-1:0]  blink_cnt, blink_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic           phase, phase_n;
    logic [W-1:0]   pat_q, pat_n, led_n;
    logic           blink_q, blink_qn;
    logic [NREQ-1:0] pre, grant_n;
    logic           tick, wrap, grant_new, lat;
    function automatic logic [GW-1:0] lowest(input logic [NREQ-1:0] v);
        lowest = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (v[i]) lowest = GW'(i);
    endfunction
    always_comb begin
        state_n   = state;
        g_n       = g;
        grant_new = 1'b0;
        lat       = 1'b0;
        pre       = '0;
        for (int i = 0; i < NREQ; i++)
            pre[i] = req_i[i] && (i < int'(g));
        if (state == IDLE) begin
            if (|req_i) begin
                grant_new = 1'b1;
                g_n       = lowest(req_i);
                state_n   = OWN;
            end
        end else if (|pre) begin
            grant_new = 1'b1;
            g_n       = lowest(pre);
        end else if (req_i[g]) begin
            lat = 1'b1;
        end else if (hold_cnt == '0) begin
            if (|req_i) begin
                grant_new = 1'b1;
                g_n       = lowest(req_i);
            end else begin
                state_n = IDLE;
            end
        end
        // a new grant restarts the timebase so a blinking pattern begins ON
        tick     = tick_cnt == TW'(TICK_DIV - 1);
        wrap     = tick && blink_cnt == BW'(BLINK_TICKS - 1);
        tick_n   = (grant_new || tick) ? '0 : tick_cnt + 1'b1;
        blink_n  = (grant_new || wrap) ? '0 : tick ? blink_cnt + 1'b1 : blink_cnt;
        phase_n  = grant_new ? 1'b1 : phase ^ wrap;
        hold_n   = grant_new ? HW'(MIN_HOLD) :
                   (state == OWN && tick && hold_cnt != '0) ? hold_cnt - 1'b1 : hold_cnt;
        pat_n    = (grant_new || lat) ? pat_i[int'(g_n)*W +: W] : pat_q;
        blink_qn = (grant_new || lat) ? blink_i[g_n] : blink_q;
        led_n    = state_n == OWN ? ((blink_qn && !phase_n) ? '0 : pat_n) : W'(phase_n);
        grant_n  = state_n == OWN ? NREQ'(1) << g_n : '0;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            g         <= '0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            hold_cnt  <= '0;
            phase     <= 1'b0;
            pat_q     <= '0;
            blink_q   <= 1'b0;
            led_o     <= '0;
            grant_o   <= '0;
            busy_o    <= 1'b0;
        end else begin
            state     <= state_n;
            g         <= g_n;
            tick_cnt  <= tick_n;
            blink_cnt <= blink_n;
            hold_cnt  <= hold_n;
            phase     <= phase_n;
            pat_q     <= pat_n;
            blink_q   <= blink_qn;
            led_o     <= led_n;
            grant_o   <= grant_n;
            busy_o    <= state_n == OWN;
        end
    end
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: scenario tasks with hand-derived per-cycle expectations queued and popped after each edge
module tb_led_arbiter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  req_i = '0;
    logic [11:0] pat_i = '0;
    logic [2:0]  blink_i = '0;
    logic [3:0]  led_o;
    logic [2:0]  grant_o;
    logic        busy_o;
    logic [7:0]  sb[$];
    logic [7:0]  e, got;
    int compared = 0;
    int mismatched = 0;

    led_arbiter #(.NREQ(3), .W(4), .TICK_DIV(4), .BLINK_TICKS(2), .MIN_HOLD(3)) dut (
        .clk(clk), .resetn(resetn), .req_i(req_i), .pat_i(pat_i),
        .blink_i(blink_i), .led_o(led_o), .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // expectation word is {busy, grant[2:0], led[3:0]}
    function automatic logic [7:0] ex(input logic b, input logic [2:0] gr, input logic [3:0] l);
        return {b, gr, l};
    endfunction

    task automatic do_reset();
        resetn  = 1'b0;
        req_i   = '0;
        pat_i   = '0;
        blink_i = '0;
        #7;
        @(negedge clk) resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        sb.push_back(ex(1'b0, 3'b000, 4'b0000));
        got = {busy_o, grant_o, led_o};
        e = sb.pop_front();
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL reset: got %b want %b", got, e);
        end
    endtask

    task automatic test_idle_heartbeat();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            sb.push_back(ex(1'b0, 3'b000, {3'b000, k >= 8 && k < 16}));
            @(posedge clk); #1;
            got = {busy_o, grant_o, led_o};
            e = sb.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL idle_heartbeat cyc %0d: got %b want %b", k, got, e);
            end
        end
    endtask

    task automatic test_single_solid();
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            if (k == 1) begin req_i = 3'b010; pat_i[7:4] = 4'b1010; end
            if (k == 2) pat_i[7:4] = 4'b1100;
            if (k == 3) begin req_i = 3'b000; pat_i[7:4] = 4'b0000; end
            sb.push_back(k == 1 ? ex(1'b1, 3'b010, 4'b1010) :
                         k <= 13 ? ex(1'b1, 3'b010, 4'b1100) :
                         k <= 16 ? ex(1'b0, 3'b000, 4'b0000) : ex(1'b0, 3'b000, 4'b0001));
            @(posedge clk); #1;
            got = {busy_o, grant_o, led_o};
            e = sb.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL single_solid cyc %0d: got %b want %b", k, got, e);
            end
        end
    endtask

    task automatic test_preempt();
        do_reset();
        for (int k = 1; k <= 21; k++) begin
            if (k == 1) begin
                req_i = 3'b010; pat_i[7:4] = 4'b1010; pat_i[3:0] = 4'b1111; blink_i = 3'b001;
            end
            if (k == 4) req_i = 3'b011;
            sb.push_back(k <= 3 ? ex(1'b1, 3'b010, 4'b1010) :
                         (k <= 11 || k >= 20) ? ex(1'b1, 3'b001, 4'b1111) : ex(1'b1, 3'b001, 4'b0000));
            @(posedge clk); #1;
            got = {busy_o, grant_o, led_o};
            e = sb.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL preempt cyc %0d: got %b want %b", k, got, e);
            end
        end
    endtask

    task automatic test_no_low_preempt();
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            if (k == 1) begin req_i = 3'b001; pat_i[3:0] = 4'b0110; pat_i[11:8] = 4'b1001; end
            if (k == 3) req_i = 3'b101;
            if (k == 15) req_i = 3'b100;
            sb.push_back(k <= 14 ? ex(1'b1, 3'b001, 4'b0110) : ex(1'b1, 3'b100, 4'b1001));
            @(posedge clk); #1;
            got = {busy_o, grant_o, led_o};
            e = sb.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL no_low_preempt cyc %0d: got %b want %b", k, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 28; k++) begin
            if (k == 1) begin
                req_i = 3'b111; pat_i = {4'b1100, 4'b0101, 4'b0001};
            end
            if (k == 14) req_i = 3'b110;
            if (k == 15) req_i = 3'b100;
            sb.push_back(k <= 13 ? ex(1'b1, 3'b001, 4'b0001) :
                         k <= 26 ? ex(1'b1, 3'b010, 4'b0101) : ex(1'b1, 3'b100, 4'b1100));
            @(posedge clk); #1;
            got = {busy_o, grant_o, led_o};
            e = sb.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", k, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_i = 3'b010;
        pat_i[7:4] = 4'b1010;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(ex(1'b1, 3'b010, 4'b1010));
            @(posedge clk); #1;
            got = {busy_o, grant_o, led_o};
            e = sb.pop_front();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL async_reset own cyc %0d: got %b want %b", k, got, e);
            end
        end
        #2 resetn = 1'b0;
        sb.push_back(ex(1'b0, 3'b000, 4'b0000));
        #1;
        got = {busy_o, grant_o, led_o};
        e = sb.pop_front();
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL async_reset no_edge: got %b want %b", got, e);
        end
        pat_i[7:4] = 4'b0011;
        @(negedge clk) resetn = 1'b1;
        sb.push_back(ex(1'b1, 3'b010, 4'b0011));
        @(posedge clk); #1;
        got = {busy_o, grant_o, led_o};
        e = sb.pop_front();
        compared++;
        if (got !== e) begin
            mismatched++;
            $display("FAIL async_reset regrant: got %b want %b", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_idle_heartbeat();
        test_single_solid();
        test_preempt();
        test_no_low_preempt();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
